// File: rtl/replacer_extend_p.sv
// Run-length replacer: each count word selects a copy run (video words passed through)
// or a replace run (FILL words inserted, or video words dropped when REPL_MODE=1).
module replacer_extend_p #(
    parameter int unsigned        DATA_W    = 8,
    parameter int unsigned        CNT_W     = 8,
    parameter int unsigned        REPL_MODE = 0,
    parameter logic [DATA_W-1:0]  FILL      = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic [DATA_W-1:0] vid_in,
    input  logic [CNT_W-1:0]  cnt_in,
    input  logic              vid_empty,
    input  logic              cnt_empty,
    input  logic              last_sign_in,
    input  logic              out_afull,
    output logic              vid_rd,
    output logic              cnt_rd,
    output logic [DATA_W-1:0] data_out,
    output logic              data_wr,
    output logic              frame_done
);

    typedef enum logic [2:0] {IDLE, LOAD, COPY, REPL, DROP} state_t;

    state_t            r_state;
    logic [CNT_W-2:0]  r_cnt;
    logic              r_last;
    logic              r_rd_d1;
    logic              r_data_wr;
    logic              r_frame_done;
    logic [DATA_W-1:0] r_data_out;

    logic              w_vid_rd;
    logic              w_cnt_rd;
    logic              w_fill_issue;
    logic              w_step;
    logic [CNT_W-2:0]  w_n;
    logic [CNT_W-2:0]  w_cnt_dec;

    // Strobes are combinational so they drop the very cycle empty/afull rises.
    always_comb begin
        w_n          = cnt_in[CNT_W-2:0];
        w_cnt_dec    = r_cnt - 1'b1;
        w_cnt_rd     = rst && clk_en && (r_state == IDLE) && !cnt_empty;
        w_vid_rd     = rst && clk_en && !vid_empty &&
                       (((r_state == COPY) && !out_afull) || (r_state == DROP));
        w_fill_issue = rst && clk_en && (r_state == REPL) && !out_afull;
        w_step       = w_vid_rd || w_fill_issue;
    end

    assign vid_rd     = w_vid_rd;
    assign cnt_rd     = w_cnt_rd;
    assign data_out   = r_data_out;
    assign data_wr    = r_data_wr && clk_en;
    assign frame_done = r_frame_done && clk_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_last       <= 1'b0;
            r_rd_d1      <= 1'b0;
            r_data_wr    <= 1'b0;
            r_frame_done <= 1'b0;
            r_data_out   <= '0;
        end else if (clk_en) begin
            r_frame_done <= 1'b0;
            r_rd_d1      <= w_vid_rd && (r_state == COPY);

            // A copy capture and a fill issue can never coincide: runs are separated by IDLE/LOAD.
            if (r_rd_d1) begin
                r_data_out <= vid_in;
                r_data_wr  <= 1'b1;
            end else if (w_fill_issue) begin
                r_data_out <= FILL;
                r_data_wr  <= 1'b1;
            end else begin
                r_data_wr  <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_cnt_rd) r_state <= LOAD;
                end
                LOAD: begin
                    r_cnt  <= w_n;
                    r_last <= last_sign_in;
                    if (w_n == '0) begin
                        r_state      <= IDLE;
                        r_frame_done <= last_sign_in;
                    end else if (!cnt_in[CNT_W-1]) begin
                        r_state <= COPY;
                    end else if (REPL_MODE == 0) begin
                        r_state <= REPL;
                    end else begin
                        r_state <= DROP;
                    end
                end
                COPY, REPL, DROP: begin
                    if (w_step) begin
                        r_cnt <= w_cnt_dec;
                        if (w_cnt_dec == '0) begin
                            r_state      <= IDLE;
                            r_frame_done <= r_last;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_replacer_extend_p.sv
// Bench for replacer_extend_p: two instances (insert mode, drop mode) fed by FIFO models,
// with a run-level reference model producing the expected output word stream.
module tb_replacer_extend_p;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, clk_en, fifo_clr;
    logic [7:0] vid_in [2];
    logic [7:0] cnt_in [2];
    logic [7:0] data_out [2];
    logic       vid_empty [2], cnt_empty [2], last_sign_in [2], out_afull [2];
    logic       vid_rd [2], cnt_rd [2], data_wr [2], frame_done [2];

    replacer_extend_p #(.DATA_W(8), .CNT_W(8), .REPL_MODE(0), .FILL(8'h00)) u_ins (
        .clk(clk), .rst(rst_n), .clk_en(clk_en),
        .vid_in(vid_in[0]), .cnt_in(cnt_in[0]),
        .vid_empty(vid_empty[0]), .cnt_empty(cnt_empty[0]),
        .last_sign_in(last_sign_in[0]), .out_afull(out_afull[0]),
        .vid_rd(vid_rd[0]), .cnt_rd(cnt_rd[0]),
        .data_out(data_out[0]), .data_wr(data_wr[0]), .frame_done(frame_done[0])
    );

    replacer_extend_p #(.DATA_W(8), .CNT_W(8), .REPL_MODE(1), .FILL(8'h00)) u_drop (
        .clk(clk), .rst(rst_n), .clk_en(clk_en),
        .vid_in(vid_in[1]), .cnt_in(cnt_in[1]),
        .vid_empty(vid_empty[1]), .cnt_empty(cnt_empty[1]),
        .last_sign_in(last_sign_in[1]), .out_afull(out_afull[1]),
        .vid_rd(vid_rd[1]), .cnt_rd(cnt_rd[1]),
        .data_out(data_out[1]), .data_wr(data_wr[1]), .frame_done(frame_done[1])
    );

    // FIFO models: data appears on *_in the cycle after the read strobe
    logic [7:0] vmem [2][512];
    logic [7:0] cmem [2][64];
    logic       lmem [2][64];
    int         vhead [2], vtail [2], chead [2], ctail [2];
    logic       vhold [2];

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            vid_empty[k] = (vhead[k] == vtail[k]) || vhold[k];
            cnt_empty[k] = (chead[k] == ctail[k]);
        end
    end

    always @(posedge clk or posedge fifo_clr) begin
        if (fifo_clr) begin
            for (int k = 0; k < 2; k++) begin
                vhead[k] <= 0;
                chead[k] <= 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (vid_rd[k] && !vid_empty[k]) begin
                    vid_in[k] <= vmem[k][vhead[k]];
                    vhead[k]  <= vhead[k] + 1;
                end
                if (cnt_rd[k] && !cnt_empty[k]) begin
                    cnt_in[k]       <= cmem[k][chead[k]];
                    last_sign_in[k] <= lmem[k][chead[k]];
                    chead[k]        <= chead[k] + 1;
                end
            end
        end
    end

    // Reference model state and observation logs
    logic [7:0] emem [2][1024];
    int etail [2], ewptr [2], mptr [2], exp_frames [2], got_frames [2];
    int nvrd [2], ncrd [2];
    int rdlog [512];
    int crdlog [64];
    int cyc, last_wr_cyc, fd_cyc, afull_cyc;
    int checks, failures;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_vid(input int k, input logic [7:0] v);
        vmem[k][vtail[k]] = v;
        vtail[k] = vtail[k] + 1;
    endtask

    // Expected output of one run, derived from the run rules and the queued video words.
    task automatic push_run(input int k, input logic [7:0] c, input logic last, input int mode);
        int n;
        n = int'(c[6:0]);
        if (!c[7]) begin
            for (int i = 0; i < n; i++) begin
                emem[k][etail[k]] = vmem[k][mptr[k]];
                etail[k]++;
                mptr[k]++;
            end
        end else if (mode == 0) begin
            for (int i = 0; i < n; i++) begin
                emem[k][etail[k]] = 8'h00;
                etail[k]++;
            end
        end else begin
            mptr[k] += n;
        end
        if (last) exp_frames[k]++;
        cmem[k][ctail[k]] = c;
        lmem[k][ctail[k]] = last;
        ctail[k] = ctail[k] + 1;
    endtask

    task automatic wait_done(input int k, input int budget, input string name);
        int t;
        t = 0;
        while ((ewptr[k] != etail[k] || chead[k] != ctail[k]) && t < budget) begin
            @(posedge clk);
            t++;
        end
        repeat (6) @(posedge clk);
        #1;
        chk({name, " words written"}, ewptr[k], etail[k]);
        chk({name, " frame_done pulses"}, got_frames[k], exp_frames[k]);
    endtask

    int base_rd, base_crd, base_wr, t;

    initial begin
        checks = 0; failures = 0; cyc = 0; afull_cyc = 0;
        last_wr_cyc = 0; fd_cyc = 0;
        rst_n = 1'b0; clk_en = 1'b1; fifo_clr = 1'b0;
        for (int k = 0; k < 2; k++) begin
            vtail[k] = 0; ctail[k] = 0; vhold[k] = 1'b0; out_afull[k] = 1'b0;
            etail[k] = 0; ewptr[k] = 0; mptr[k] = 0; exp_frames[k] = 0;
            got_frames[k] = 0; nvrd[k] = 0; ncrd[k] = 0;
        end
        #1 fifo_clr = 1'b1;
        #1 fifo_clr = 1'b0;

        fork
            forever begin
                @(negedge clk);
                cyc++;
                if (rst_n) begin
                    for (int k = 0; k < 2; k++) begin
                        if (data_wr[k]) begin
                            if (ewptr[k] >= etail[k])
                                chk($sformatf("extra write dut%0d", k), ewptr[k] + 1, etail[k]);
                            else
                                chk($sformatf("data_out dut%0d word %0d", k, ewptr[k]),
                                    int'(data_out[k]), int'(emem[k][ewptr[k]]));
                            ewptr[k]++;
                            if (k == 0) begin
                                last_wr_cyc = cyc;
                                if (out_afull[0])
                                    chk("write within 2 cycles of afull", int'(afull_cyc < 2), 1);
                            end
                        end
                        if (vid_rd[k]) begin
                            chk($sformatf("vid_rd while empty dut%0d", k), int'(vid_empty[k]), 0);
                            if (k == 0) rdlog[nvrd[0]] = cyc;
                            nvrd[k]++;
                        end
                        if (cnt_rd[k]) begin
                            chk($sformatf("cnt_rd while empty dut%0d", k), int'(cnt_empty[k]), 0);
                            if (k == 0) crdlog[ncrd[0]] = cyc;
                            ncrd[k]++;
                        end
                        if (frame_done[k]) begin
                            got_frames[k]++;
                            if (k == 0) fd_cyc = cyc;
                        end
                    end
                end
                if (rst_n && out_afull[0]) begin
                    chk("vid_rd during afull", int'(vid_rd[0]), 0);
                    afull_cyc++;
                end else begin
                    afull_cyc = 0;
                end
            end
        join_none

        // Basic copy then insert; queued during reset so cnt_empty is low while reset holds
        push_vid(0, 8'h11); push_vid(0, 8'h22); push_vid(0, 8'h33);
        push_run(0, 8'h03, 1'b0, 0);
        push_run(0, 8'h82, 1'b0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset vid_rd", int'(vid_rd[0]), 0);
        chk("reset cnt_rd", int'(cnt_rd[0]), 0);
        chk("reset data_wr", int'(data_wr[0]), 0);
        chk("reset data_out", int'(data_out[0]), 0);
        chk("reset frame_done", int'(frame_done[0]), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        wait_done(0, 60, "copy+insert");
        chk("model word0", int'(emem[0][0]), 8'h11);
        chk("model word1", int'(emem[0][1]), 8'h22);
        chk("model word2", int'(emem[0][2]), 8'h33);
        chk("model word3", int'(emem[0][3]), 8'h00);
        chk("model word4", int'(emem[0][4]), 8'h00);
        chk("copy+insert writes", ewptr[0], 5);
        chk("copy+insert vid_rd count", nvrd[0], 3);

        // Drop mode: two words discarded, one copied
        push_vid(1, 8'hA0); push_vid(1, 8'hA1); push_vid(1, 8'hA2);
        push_run(1, 8'h82, 1'b0, 1);
        push_run(1, 8'h01, 1'b0, 1);
        wait_done(1, 60, "drop");
        chk("drop model length", etail[1], 1);
        chk("drop model word", int'(emem[1][0]), 8'hA2);
        chk("drop vid_rd count", nvrd[1], 3);

        // Copy with vid FIFO starved for three cycles, last-of-frame
        base_rd = nvrd[0];
        for (int i = 0; i < 5; i++) push_vid(0, 8'h51 + 8'(i));
        push_run(0, 8'h05, 1'b1, 0);
        t = 0;
        while (nvrd[0] == base_rd && t < 50) begin @(posedge clk); t++; end
        #1 vhold[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1 vhold[0] = 1'b0;
        wait_done(0, 60, "starved copy");
        chk("starved vid_rd count", nvrd[0] - base_rd, 5);
        chk("starved read gap", rdlog[base_rd + 1] - rdlog[base_rd], 4);
        chk("frame_done after 5th read", fd_cyc - rdlog[base_rd + 4], 1);

        // Zero-length run followed by a single fill
        base_crd = ncrd[0];
        push_run(0, 8'h00, 1'b0, 0);
        push_run(0, 8'h81, 1'b0, 0);
        wait_done(0, 60, "zero run");
        chk("zero run cnt_rd count", ncrd[0] - base_crd, 2);
        chk("first cnt_rd to fill write", last_wr_cyc - crdlog[base_crd], 5);

        // Backpressure during copy, clock enable gap during insert
        base_rd = nvrd[0];
        base_wr = ewptr[0];
        for (int i = 0; i < 12; i++) push_vid(0, 8'h60 + 8'(i));
        push_run(0, 8'h0C, 1'b0, 0);
        push_run(0, 8'h86, 1'b0, 0);
        t = 0;
        while (nvrd[0] < base_rd + 3 && t < 50) begin @(posedge clk); t++; end
        #1 out_afull[0] = 1'b1;
        repeat (10) @(posedge clk);
        #1 out_afull[0] = 1'b0;
        t = 0;
        while (ewptr[0] <= base_wr + 12 && t < 200) begin @(posedge clk); t++; end
        #1 clk_en = 1'b0;
        repeat (3) @(posedge clk);
        #1 clk_en = 1'b1;
        wait_done(0, 100, "afull/clk_en");
        chk("afull/clk_en total writes", ewptr[0] - base_wr, 18);
        chk("afull/clk_en vid_rd count", nvrd[0] - base_rd, 12);

        // Reset in the middle of a long copy run
        base_rd = nvrd[0];
        for (int i = 0; i < 127; i++) push_vid(0, 8'h80 + 8'(i));
        push_run(0, 8'h7F, 1'b0, 0);
        t = 0;
        while (nvrd[0] < base_rd + 20 && t < 100) begin @(posedge clk); t++; end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid-run reset vid_rd", int'(vid_rd[0]), 0);
        chk("mid-run reset cnt_rd", int'(cnt_rd[0]), 0);
        chk("mid-run reset data_wr", int'(data_wr[0]), 0);
        chk("mid-run reset data_out", int'(data_out[0]), 0);
        chk("mid-run reset frame_done", int'(frame_done[0]), 0);
        ewptr[0] = etail[0];
        mptr[0]  = vhead[0];
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        base_rd  = nvrd[0];
        base_crd = ncrd[0];
        repeat (4) @(posedge clk);
        #1;
        chk("no vid_rd before cnt_rd after reset", nvrd[0] - base_rd, 0);
        push_run(0, 8'h02, 1'b1, 0);
        wait_done(0, 60, "post-reset run");
        chk("post-reset vid_rd count", nvrd[0] - base_rd, 2);
        chk("cnt_rd precedes vid_rd", int'(crdlog[base_crd] < rdlog[base_rd]), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/replacer_extend_p.md
REPLACER_EXTEND_P -- requirements
Module: replacer_extend_p

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of vid_in and data_out.
REQ-002 SHALL have parameter CNT_W, default 8: width of cnt_in; bit CNT_W-1 is the run type (0 copy, 1 replace), bits CNT_W-2:0 are the run length N.
REQ-003 SHALL have parameter REPL_MODE, default 0: 0 means a replace run inserts FILL words; 1 means a replace run reads and discards N vid words.
REQ-004 SHALL have parameter FILL, default {DATA_W{1'b0}}: word emitted in insert runs.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 clk_en  in  1  clock enable; while low, no state, counter or register changes.
REQ-008 vid_in  in  DATA_W  video FIFO read data; valid the cycle after vid_rd.
REQ-009 cnt_in  in  CNT_W  count FIFO read data; valid the cycle after cnt_rd.
REQ-010 vid_empty, cnt_empty  in  1 each  FIFO empty flags.
REQ-011 last_sign_in  in  1  sampled with cnt_in; marks the run as last of frame.
REQ-012 out_afull  in  1  downstream almost-full; at least 2 words of slack are guaranteed.
REQ-013 vid_rd, cnt_rd  out  1 each  FIFO read strobes.
REQ-014 data_out  out  DATA_W, data_wr  out  1  registered output word and write strobe.
REQ-015 frame_done  out  1  one-cycle pulse when a last-of-frame run completes.

Function
REQ-016 FSM SHALL have states IDLE, LOAD, COPY, REPL, DROP; transitions below occur only on cycles with clk_en=1.
REQ-017 IDLE: if cnt_empty=0, assert cnt_rd for one cycle and go to LOAD; otherwise stay in IDLE.
REQ-018 LOAD: latch type, N and last_sign_in. If N=0, go to IDLE; with last set, pulse frame_done the next cycle. If N>0, go to COPY (type 0), REPL (type 1, REPL_MODE 0) or DROP (type 1, REPL_MODE 1).
REQ-019 COPY: each cycle with vid_empty=0 and out_afull=0, assert vid_rd and decrement the remaining count. data_wr=1 with data_out=vid_in latched is registered one cycle after vid_in is valid, i.e. 2 cycles after vid_rd.
REQ-020 REPL: each cycle with out_afull=0, decrement the remaining count; the next cycle has data_wr=1 and data_out=FILL. vid_rd stays 0.
REQ-021 DROP: each cycle with vid_empty=0, assert vid_rd and decrement; data_wr stays 0 and out_afull is ignored.
REQ-022 When the decrement takes the remaining count from 1 to 0, the FSM SHALL go to IDLE; if the latched last flag is set, frame_done pulses the cycle after.
REQ-023 vid_rd SHALL never assert while vid_empty=1; cnt_rd SHALL never assert while cnt_empty=1 or outside IDLE.
REQ-024 Back-to-back runs SHALL add exactly 2 idle issue cycles (IDLE, LOAD) between the last read/issue of one run and the first of the next.
REQ-025 The remaining counter SHALL be CNT_W-1 bits wide; a maximal N of 2^(CNT_W-1)-1 SHALL complete without wrap.
REQ-026 data_wr and frame_done SHALL be ANDed with clk_en at the port, so nothing is written twice while clk_en is low.
REQ-027 When out_afull rises, the issue SHALL stop the same cycle; at most 2 in-flight words may still be written.

Reset
REQ-028 On rst=0, asynchronously: state IDLE, counter 0, vid_rd=0, cnt_rd=0, data_wr=0, data_out=0, frame_done=0.
REQ-029 A reset mid-run SHALL abandon the run; after release, the first action is a count-FIFO read.

Verification
REQ-030 Defaults, cnt stream {0x03, 0x82}, vid supplies 0x11,0x22,0x33 -> data_out 0x11,0x22,0x33,0x00,0x00, five data_wr pulses, three vid_rd.
REQ-031 REPL_MODE=1, cnt {0x82, 0x01}, vid 0xA0,0xA1,0xA2 -> two reads discarded, output only 0xA2, with three vid_rd total.
REQ-032 cnt 0x05 with last_sign_in=1, vid_empty high for cycles 2-4 of the run -> vid_rd gaps match, 5 words out, frame_done single pulse after the 5th read.
REQ-033 cnt 0x00 then 0x81 -> no output for the first run, one FILL word, and exactly 4 cnt/issue cycles from first cnt_rd to the fill issue.
REQ-034 out_afull high for 10 cycles mid-COPY, and clk_en low for 3 cycles mid-REPL -> no issue while afull, ≤2 trailing writes, no duplicate words, the total count is preserved.
REQ-035 rst pulsed low during a 0x7F copy run -> outputs zero immediately; after release, cnt_rd precedes any vid_rd.
